// File: rtl/tmds_encoder_3ch.sv
// TMDS 8b/10b encoder for the three DVI/HDMI colour channels, with running disparity per channel.
// Latency: 2 cycles from i_* to o_tmds/o_de; stage 1 builds q_m, stage 2 balances DC or emits a control token.
// Backpressure: none; one pixel is accepted every cycle.
//
// Ports:
//   i_clk, i_rst      pixel clock; asynchronous active-high reset
//   i_de              active video (1) / blanking (0)
//   i_hsync, i_vsync  syncs, sent on channel 0 as control tokens during blanking
//   i_ctl[3:0]        CTL3..CTL0 for channels 2/1 (present only when TMDS_CTL_EN is defined)
//   i_data[3]         [2]=R, [1]=G, [0]=B
//   o_tmds[3]         [0]=blue/ch0, [1]=green/ch1, [2]=red/ch2; bit 0 is sent first
//   o_de              i_de aligned to o_tmds
// Optional macro: TMDS_CTL_EN adds i_ctl; without it, channels 1/2 send the c1c0=00 token.
module tmds_encoder_3ch #(
    parameter int p_data_width = 8,
    parameter int p_sym_width  = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_de,
    input  logic                    i_hsync,
    input  logic                    i_vsync,
`ifdef TMDS_CTL_EN
    input  logic [3:0]              i_ctl,
`endif
    input  logic [p_data_width-1:0] i_data [3],
    output logic [p_sym_width-1:0]  o_tmds [3],
    output logic                    o_de
);

    generate
        if (p_data_width != 8 || p_sym_width != 10) begin : g_bad_width
            $error("tmds_encoder_3ch: only p_data_width=8 / p_sym_width=10 are supported");
        end
    endgenerate

    localparam logic [9:0] lc_tok00 = 10'b1101010100;
    localparam logic [9:0] lc_tok01 = 10'b0010101011;
    localparam logic [9:0] lc_tok10 = 10'b0101010100;
    localparam logic [9:0] lc_tok11 = 10'b1010101011;

    function automatic logic [3:0] f_popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] f_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = lc_tok00;
            2'b01:   t = lc_tok01;
            2'b10:   t = lc_tok10;
            default: t = lc_tok11;
        endcase
        return t;
    endfunction

    // Shared control pipeline: de/syncs/ctl travel with q_m, de continues to the output.
    logic       de_s1_q;
    logic       hsync_s1_q;
    logic       vsync_s1_q;
    logic       de_s2_q;
    logic [3:0] ctl_s1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            de_s1_q    <= 1'b0;
            hsync_s1_q <= 1'b0;
            vsync_s1_q <= 1'b0;
            de_s2_q    <= 1'b0;
        end else begin
            de_s1_q    <= i_de;
            hsync_s1_q <= i_hsync;
            vsync_s1_q <= i_vsync;
            de_s2_q    <= de_s1_q;
        end
    end

`ifdef TMDS_CTL_EN
    logic [3:0] ctl_s1_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctl_s1_q <= 4'd0;
        end else begin
            ctl_s1_q <= i_ctl;
        end
    end

    assign ctl_s1 = ctl_s1_q;
`else
    assign ctl_s1 = 4'd0;
`endif

    assign o_de = de_s2_q;

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [8:0]        qm_d;
        logic [8:0]        qm_q;
        logic [9:0]        sym_d;
        logic [9:0]        sym_q;
        logic signed [4:0] cnt_d;
        logic signed [4:0] cnt_q;
        logic [3:0]        n1;
        logic [3:0]        n1q;
        logic signed [4:0] diff;
        logic              use_xnor;
        logic [1:0]        ctl_c;

        if (ch == 0) begin : g_c0
            assign ctl_c = {vsync_s1_q, hsync_s1_q};
        end else if (ch == 1) begin : g_c1
            assign ctl_c = ctl_s1[1:0];
        end else begin : g_c2
            assign ctl_c = ctl_s1[3:2];
        end

        // Stage 1: transition-minimised q_m; XNOR chosen when the byte is ones-heavy.
        always_comb begin
            n1       = f_popcount(i_data[ch]);
            use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !i_data[ch][0]);
            qm_d     = '0;
            qm_d[0]  = i_data[ch][0];
            for (int i = 1; i < 8; i++) begin
                qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_data[ch][i]) : (qm_d[i-1] ^ i_data[ch][i]);
            end
            qm_d[8]  = ~use_xnor;
        end

        // Stage 2: cnt holds the ones-minus-zeros balance of emitted 10-bit data symbols.
        always_comb begin
            n1q   = f_popcount(qm_q[7:0]);
            // N1q - N0q = 2*N1q - 8, modulo 32 in two's complement
            diff  = $signed({n1q, 1'b0}) - 5'sd8;
            sym_d = f_token(ctl_c);
            cnt_d = 5'sd0;
            if (de_s1_q) begin
                if ((cnt_q == 5'sd0) || (n1q == 4'd4)) begin
                    sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                end else if ((!cnt_q[4] && (n1q > 4'd4)) || (cnt_q[4] && (n1q < 4'd4))) begin
                    // Running balance would grow: invert the payload.
                    sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d = cnt_q + $signed({3'b000, qm_q[8], 1'b0}) - diff;
                end else begin
                    sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d = cnt_q - $signed({3'b000, ~qm_q[8], 1'b0}) + diff;
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                qm_q  <= 9'd0;
                sym_q <= lc_tok00;
                cnt_q <= 5'sd0;
            end else begin
                qm_q  <= qm_d;
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
        end

        assign o_tmds[ch] = sym_q;
    end

endmodule

// File: doc/tmds_encoder_3ch.md
Name: tmds_encoder_3ch

Overview:
- DVI/HDMI TMDS 8b/10b encoder for all three colour channels.
- Sits directly downstream of the camera display top. Consumes its RGB byte triple plus de/hsync/vsync at pixel rate.
- Produces three 10-bit TMDS symbols per pixel clock for an external 10:1 serializer.
- Tracks running disparity per channel and emits control tokens during blanking.

Parameters:
- p_data_width, 8, colour bits per channel; only 8 is legal, an elaboration error is raised otherwise.
- p_sym_width, 10, TMDS symbol width; fixed, exposed for port sizing only.

Ports:
- i_clk  input  1  pixel clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_de  input  1  data enable; 1 = active video.
- i_hsync  input  1  horizontal sync, carried on channel 0 during blanking.
- i_vsync  input  1  vertical sync, carried on channel 0 during blanking.
- i_data  input  8 x [3]  unpacked byte array; [2]=R, [1]=G, [0]=B.
- o_tmds  output  10 x [3]  encoded symbols; [0]=blue/ch0, [1]=green/ch1, [2]=red/ch2; bit 0 is transmitted first.
- o_de  output  1  i_de delayed by 2 cycles, aligned to o_tmds; debug/alignment only.

Behaviour:
- Clock and reset: one clock i_clk. i_rst is asynchronous, active-high. No clock enable; one input is accepted every cycle with no back-pressure.
- Reset values: all pipeline registers clear. o_tmds[*] = 10'b1101010100 (control token for c1c0=00). o_de = 0. Disparity counters cnt[*] = 0.
- Latency: exactly 2 cycles from inputs to o_tmds/o_de.
- Stage 1 (registered), per channel:
  - N1 = popcount(D).
  - Use XNOR if N1>4, or if N1==4 and D[0]==0; otherwise use XOR.
  - q_m[0]=D[0]; q_m[i]=q_m[i-1] op D[i] for i=1..7.
  - q_m[8]=1 for XOR, 0 for XNOR.
  - de, hsync and vsync are registered alongside q_m.
- Stage 2 (registered), per channel, when de=1:
  - N1q=popcount(q_m[7:0]); N0q=8-N1q.
  - Case A, cnt==0 or N1q==N0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1q-N0q) : (N0q-N1q).
  - Case B, (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0q-N1q).
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (N1q-N0q).
- Stage 2 when de=0:
  - Token selected by {c1,c0}: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - ch0 uses {c1,c0}={vsync,hsync}; ch1 and ch2 use 00.
  - cnt is cleared to 0 on every blanking cycle.
- Arithmetic: cnt is a 5-bit signed register. N1q/N0q difference terms are computed as signed 5-bit. cnt equals (#ones − #zeros) accumulated over emitted data symbols since the last blanking cycle.
- Channel independence: the three channels share the de/sync pipeline only; each has its own cnt.
- Boundaries:
  - de rising: the first data symbol is encoded with cnt=0.
  - de falling: the token appears 2 cycles later; cnt is 0 from that cycle on.
  - Single-cycle de pulse: one data symbol, cnt reset next.
  - Reset asserted mid-line: outputs go to reset values immediately (asynchronously). After deassertion the first valid output is 2 cycles after the first sampled input.

Optional Feature:
- Macro: TMDS_CTL_EN.
- Defined: adds input port i_ctl (4 bits, CTL3..CTL0). During blanking, ch1 uses {c1,c0}={i_ctl[1],i_ctl[0]} and ch2 uses {i_ctl[3],i_ctl[2]}. i_ctl is registered in stage 1 with the syncs (same 2-cycle latency).
- Undefined: i_ctl port is absent; ch1/ch2 control bits are 00.

Test Plan:
- Reset: assert i_rst mid-stream → o_tmds[*]=0x354, o_de=0, with no clock edge required. Deassert, drive de=0, hsync=1, vsync=0 → after 2 cycles o_tmds[0]=0x0AB, o_tmds[1]=o_tmds[2]=0x354.
- Token map: de=0, sweep {vsync,hsync}=00,01,10,11 → o_tmds[0]=0x354, 0x0AB, 0x154, 0x2AB, each 2 cycles after its input.
- Disparity sequence: after blanking, de=1 with all channels 0x00 for 3 cycles → 0x100, 0x3FF, 0x100. Same pattern with 0xFF → first symbol 0x200.
- Latency/alignment: a single-cycle de pulse with R=0x12, G=0x34, B=0x56 → o_de high for exactly 1 cycle, 2 cycles later. Symbols must match the reference model; the token resumes on the next cycle.
- Random soak: 100k cycles of random data with realistic 640x480 de/sync timing. Every symbol must match a bit-accurate model. Each decoded symbol must return the original byte/sync. Running disparity must never exceed ±15. With TMDS_CTL_EN, random i_ctl must appear on ch1/ch2 tokens.
